alarm_display_scan: RTL
=======================

// Module: alarm_display_scan
// PURPOSE
//  Downstream of the alarm clock core. Takes its six BCD time digits plus Alarm/AL_ON and drives a
//  multiplexed 6-digit common-anode 7-segment display (HH.MM.SS). Time-multiplexes digits,
//  snapshots inputs once per frame (no tearing), blanks invalid codes and optional leading hour
//  zero, and flashes the whole display while Alarm is asserted.
// PARAMETERS
//  SCAN_DIV      50000  clocks per digit slot (>=2)
//  BLINK_FRAMES  50     full scan frames per blink half-period (>=1)
//  LZB           1      1 = blank H_out1 digit when it is 0
// PORTS
//  clk      in   1  single clock for all logic
//  reset    in   1  asynchronous, active-low reset
//  H_out1   in   2  hour tens (BCD) from alarm clock core
//  H_out0   in   4  hour units
//  M_out1   in   4  minute tens
//  M_out0   in   4  minute units
//  S_out1   in   4  second tens
//  S_out0   in   4  second units
//  Alarm    in   1  alarm ringing; enables flashing
//  AL_ON    in   1  alarm armed; shown on digit-0 dp
//  an       out  6  anode enables, active-low one-hot; an[0]=S_out0 ... an[5]=H_out1
//  seg      out  7  segments active-low, seg[6:0]=a,b,c,d,e,f,g
//  dp       out  1  decimal point, active-low
// BEHAVIOUR
//  Reset (async, reset=0): an=6'b111111, seg=7'b1111111, dp=1; prescaler, digit index, frame
//   counter, blink phase and all six shadow digit regs = 0. Mid-operation reset clears immediately.
//  Prescaler: counts 0..SCAN_DIV-1, wraps; tick = (prescaler==SCAN_DIV-1).
//  Digit index: 0..5; on tick advance, 5->0 wrap. Frame end = tick while index==5.
//  Shadow capture: at frame end all six inputs sampled into shadow regs (H_out1 zero-extended);
//   displayed data comes only from shadow. First frame after reset shows shadow=0.
//  Frame counter: 0..BLINK_FRAMES-1, increments at frame end; on wrap toggles blink phase.
//   While Alarm=0: frame counter and blink phase held at 0 (flash always starts in visible phase).
//  Output regs (updated every clk from current index/shadow, 1-cycle latency):
//   digit d = shadow[index]; seg = decode(d); an = ~(6'b1 << index);
//   decode active-low: 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100
//    6=0100000 7=0001111 8=0000000 9=0000100; codes 10-15 -> 1111111.
//   LZB=1 and index==5 and shadow H1==0 -> seg=1111111 (anode still driven).
//   dp=0 at index 2 and 4 (HH.MM.SS separators); dp=~AL_ON at index 0; else dp=1.
//   Alarm=1 and blink phase=1 -> an=6'b111111, seg=1111111, dp=1. Alarm falling mid-blank ->
//   normal output on next clk. Alarm and frame end same cycle: capture and count both happen.
//  Exactly one anode low at any time outside blanking/reset; no combinational path input->output.
// TESTING (SCAN_DIV=4, BLINK_FRAMES=2, LZB=1 unless stated)
//  1 reset=0 -> an=111111 seg=1111111 dp=1; release, 1 clk -> an=111110; seg=0000001 (shadow 0).
//  2 inputs H=10 M=20 S=35 held; after first frame end -> an=111110 seg=0100100 (5), dp=~AL_ON;
//    index5 an=011111 seg=1001111 (1); index2 dp=0, index4 dp=0; each digit held 4 clks.
//  3 change S_out0 5->7 mid-frame -> digit0 still 0100100 until next frame end, then 0001111.
//  4 S_out1=4'hC -> index1 seg=1111111; H_out1=0 -> index5 seg=1111111, an=011111.
//  5 Alarm=1 -> 2 frames visible, 2 frames an=111111, repeating; drop Alarm in blank -> next clk
//    an one-hot again, blink phase 0.
//  6 assert reset mid-scan at index 3 -> outputs blanked same cycle, counters/shadow 0 after release.

Source files
------------

// File: rtl/alarm_display_scan.sv
// alarm_display_scan
//   Drives a multiplexed 6-digit common-anode 7-segment display (HH.MM.SS)
//   from the alarm clock core's BCD time digits.
//   - One digit is lit per slot of SCAN_DIV clocks, scanning index 0..5.
//   - All six digits are snapshotted into shadow registers once per frame,
//     so a frame never mixes old and new time values.
//   - Codes above 9 are blanked. With LZB=1, a zero hour-tens digit is blanked.
//   - While Alarm is high, the display alternates between BLINK_FRAMES visible
//     frames and BLINK_FRAMES fully blanked frames.
// Ports
//   clk     : single clock for all logic
//   reset   : asynchronous, active-low reset
//   H_out1  : hour tens (2-bit BCD)
//   H_out0, M_out1, M_out0, S_out1, S_out0 : remaining BCD digits
//   Alarm   : alarm ringing, enables flashing
//   AL_ON   : alarm armed, shown on the digit-0 decimal point
//   an      : anode enables, active-low one-hot, an[0]=S_out0 .. an[5]=H_out1
//   seg     : segments a..g on seg[6:0], active-low
//   dp      : decimal point, active-low
module alarm_display_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 50,
  parameter bit LZB          = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] H_out1,
  input  logic [3:0] H_out0,
  input  logic [3:0] M_out1,
  input  logic [3:0] M_out0,
  input  logic [3:0] S_out1,
  input  logic [3:0] S_out0,
  input  logic       Alarm,
  input  logic       AL_ON,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0] prescaler_reg;
  logic [2:0]    index_reg;
  logic [FW-1:0] frame_reg;
  logic          blink_reg;
  logic [3:0]    shadow_reg [6];
  logic [3:0]    din [6];

  logic          tick;
  logic          frame_end;
  logic [3:0]    digit;
  logic [5:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  // Input digits in scan order; hour tens is widened to a full BCD nibble.
  assign din[0] = S_out0;
  assign din[1] = S_out1;
  assign din[2] = M_out0;
  assign din[3] = M_out1;
  assign din[4] = H_out0;
  assign din[5] = {2'b00, H_out1};

  assign tick      = (prescaler_reg == PRE_LAST);
  assign frame_end = tick && (index_reg == 3'd5);

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0000001;
      4'd1:    decode = 7'b1001111;
      4'd2:    decode = 7'b0010010;
      4'd3:    decode = 7'b0000110;
      4'd4:    decode = 7'b1001100;
      4'd5:    decode = 7'b0100100;
      4'd6:    decode = 7'b0100000;
      4'd7:    decode = 7'b0001111;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0000100;
      default: decode = 7'b1111111;
    endcase
  endfunction

  // Slot timing: prescaler sets the slot length, index selects the digit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler_reg <= '0;
      index_reg     <= '0;
    end else begin
      if (tick) begin
        prescaler_reg <= '0;
        index_reg     <= (index_reg == 3'd5) ? 3'd0 : index_reg + 3'd1;
      end else begin
        prescaler_reg <= prescaler_reg + PW'(1);
      end
    end
  end

  // Frame snapshot of all six digits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 6; i++) shadow_reg[i] <= '0;
    end else if (frame_end) begin
      for (int i = 0; i < 6; i++) shadow_reg[i] <= din[i];
    end
  end

  // Blink timing only runs while the alarm rings; holding it at zero otherwise
  // guarantees every flash sequence opens with a visible phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_reg <= '0;
      blink_reg <= 1'b0;
    end else if (!Alarm) begin
      frame_reg <= '0;
      blink_reg <= 1'b0;
    end else if (frame_end) begin
      if (frame_reg == FRM_LAST) begin
        frame_reg <= '0;
        blink_reg <= ~blink_reg;
      end else begin
        frame_reg <= frame_reg + FW'(1);
      end
    end
  end

  always_comb begin
    digit    = shadow_reg[index_reg];
    seg_next = decode(digit);
    an_next  = ~(6'b000001 << index_reg);
    if (LZB && (index_reg == 3'd5) && (shadow_reg[5] == 4'd0)) begin
      seg_next = 7'b1111111;
    end
    case (index_reg)
      3'd0:       dp_next = ~AL_ON;
      3'd2, 3'd4: dp_next = 1'b0;
      default:    dp_next = 1'b1;
    endcase
    if (Alarm && blink_reg) begin
      an_next  = 6'b111111;
      seg_next = 7'b1111111;
      dp_next  = 1'b1;
    end
  end

  // Registered outputs keep input-to-pin paths out of the display drivers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= 6'b111111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule
